// File: rtl/aes_pkg.sv
// Shared AES widths plus word-slicing and byte-reversal helpers used by the
// output serializer.
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_WORDS  = 4;

  // Word 0 is the most-significant 32 bits of the block.
  function automatic logic [AES_WORD_W-1:0] word_sel(
    input logic [AES_BLK_W-1:0] blk,
    input logic [1:0]           idx
  );
    logic [AES_WORD_W-1:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [AES_WORD_W-1:0] bswap32(
    input logic [AES_WORD_W-1:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_out_serializer_if.sv
// Word stream from the AES output serializer to its consumer.
// A word transfers on a rising clock edge where ser_valid & ser_ready are both
// high; while ser_valid is high and ser_ready low, ser_data/ser_last hold.
interface aes_ser_if;
  import aes_pkg::*;

  logic                  ser_valid;
  logic                  ser_ready;
  logic [AES_WORD_W-1:0] ser_data;
  logic                  ser_last;

  modport master (output ser_valid, output ser_data, output ser_last, input ser_ready);
  modport slave  (input ser_valid, input ser_data, input ser_last, output ser_ready);

endinterface

// File: rtl/aes_blk_fifo.sv
// DEPTH x 128-bit block buffer with read/write pointers and an occupancy level.
// A push while full is accepted only when a pop happens on the same edge.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [AES_BLK_W-1:0] push_data,
  input  logic                 pop,
  output logic [AES_BLK_W-1:0] head_data,
  output logic [LW-1:0]        level,
  output logic                 full,
  output logic                 empty
);

  logic [AES_BLK_W-1:0] slots_q [DEPTH];
  logic [AES_BLK_W-1:0] slots_d [DEPTH];
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 do_push, do_pop;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign head_data = slots_q[rptr_q];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);

    slots_d = slots_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;

    if (do_push) begin
      slots_d[wptr_q] = push_data;
      wptr_d          = wptr_q + PW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    // Level cannot exceed DEPTH: a push at full requires a matching pop.
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= slots_d[i];
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/aes_out_serializer.sv
// Captures AES result blocks on the rising edge of AES_data_out_valid and
// streams each as four 32-bit words, MSW first. Define AES_SER_BSWAP_EN to
// byte-reverse every emitted word.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic                 AES_clk,
  input  logic                 AES_rst_n,
  input  logic                 AES_data_out_valid,
  input  logic [AES_BLK_W-1:0] AES_data_out,
  aes_ser_if.master            ser,
  output logic                 ser_ovf,
  output logic [LW-1:0]        ser_level
);

  logic                  vld_q, vld_d;
  logic [1:0]            widx_q, widx_d;
  logic                  ovf_q, ovf_d;

  logic                  cap, xfer, pop_blk, drop;
  logic                  fifo_full, fifo_empty;
  logic [AES_BLK_W-1:0]  head_blk;
  logic [AES_WORD_W-1:0] word;
  logic [LW-1:0]         level;

  aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (AES_clk),
    .rst_n     (AES_rst_n),
    .push      (cap),
    .push_data (AES_data_out),
    .pop       (pop_blk),
    .head_data (head_blk),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    cap     = AES_data_out_valid & ~vld_q;
    xfer    = ~fifo_empty & ser.ser_ready;
    pop_blk = xfer & (widx_q == 2'd3);
    // A completing pop on the same edge frees a slot for the new block.
    drop    = cap & fifo_full & ~pop_blk;

    vld_d  = AES_data_out_valid;
    widx_d = xfer ? widx_q + 2'd1 : widx_q;
    ovf_d  = ovf_q | drop;

    word = word_sel(head_blk, widx_q);
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      vld_q  <= 1'b0;
      widx_q <= 2'd0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      widx_q <= widx_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ser.ser_valid = ~fifo_empty;
  assign ser.ser_last  = ~fifo_empty & (widx_q == 2'd3);
`ifdef AES_SER_BSWAP_EN
  assign ser.ser_data  = bswap32(word);
`else
  assign ser.ser_data  = word;
`endif
  assign ser_ovf   = ovf_q;
  assign ser_level = level;

endmodule

// File: doc/aes_out_serializer.md
# aes_out_serializer

Downstream stage of the AES core: captures each 128-bit result block on a rising edge of `AES_data_out_valid`, buffers up to DEPTH blocks, and emits each block as four 32-bit words on a valid/ready stream, most-significant word first. It decouples the core's single-cycle result strobe from a narrower, back-pressured consumer such as a bus bridge or a result-capture FIFO.

## Interface
- DEPTH, 2, number of 128-bit block slots; power of two, ≥ 2
- `AES_clk` input 1: single clock, rising edge
- `AES_rst_n` input 1: asynchronous, active-low reset
- `AES_data_out_valid` input 1: result-valid from the AES core; level signal, edge-detected internally
- `AES_data_out` input 128: result block from the AES core; sampled on the valid rising edge
- `ser_ready` input 1: consumer ready
- `ser_valid` output 1: a word is presented
- `ser_data` output 32: current word
- `ser_last` output 1: current word is word 3 of its block
- `ser_ovf` output 1: sticky flag; a block was dropped because the buffer was full
- `ser_level` output $clog2(DEPTH)+1: number of occupied block slots

## Operation
- Edge detect: `vld_q` registers `AES_data_out_valid`. Capture strobe = `AES_data_out_valid & ~vld_q`. A valid held high for many cycles yields one capture. After reset, `vld_q` = 0, so valid high at the first clock is a capture.
- Capture writes `AES_data_out` into the tail slot, then advances the write pointer modulo DEPTH.
- Pop: a word transfers when `ser_valid & ser_ready`. The word index `widx` (2 bits) selects the head word: idx 0 = [127:96], 1 = [95:64], 2 = [63:32], 3 = [31:0]. A transfer at idx 3 frees the head slot, advances the read pointer, and sets `widx` to 0. Any other transfer increments `widx`.
- `ser_valid` = level ≠ 0. `ser_last` = `ser_valid & (widx == 3)`. `ser_data` comes combinationally from registered head slot and `widx`.
- Full: a capture while level == DEPTH and no block-completing pop in the same cycle is dropped. `ser_ovf` is set and stays set until reset.
- Simultaneous capture and block-completing pop: both take effect, level is unchanged, no drop (this also holds when full).
- Simultaneous capture and pop while empty is impossible, because `ser_valid` = 0.
- Pointer and level arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally. Level is one bit wider and saturates at DEPTH by construction.

## Timing
- Reset values: `ser_valid` 0, `ser_data` 0 (slots reset to zero), `ser_last` 0, `ser_ovf` 0, `ser_level` 0, `widx` 0, pointers 0, `vld_q` 0.
- Capture latency: strobe seen at edge N means `ser_valid` = 1 and word 0 is on `ser_data` after edge N.
- Throughput: one word per cycle with `ser_ready` held high, so 4 cycles per block.
- `ser_data` and `ser_last` are stable while `ser_valid & ~ser_ready`.
- Asserting reset mid-block discards all buffered data immediately (asynchronous). The partial block is lost; no flag is raised.

## Configuration
- `AES_SER_BSWAP_EN` defined: every emitted word is byte-reversed; word 0xAABBCCDD is emitted as 0xDDCCBBAA. Ordering of words within the block is unchanged.
- Undefined: words are emitted exactly as sliced.
- The ports are identical in both builds.

## Structure
- Shared package `aes_pkg`: `AES_BLK_W` = 128, `AES_WORD_W` = 32, `AES_WORDS` = 4.
- One sub-module, `aes_blk_fifo`: the DEPTH × 128 storage with pointers, level, push/pop, and full/empty.
- The top level holds the edge detect, `widx`, word mux, optional byte swap, and overflow flag.

## Test plan
- Reset, then a single valid pulse with block 0x00112233_44556677_8899aabb_ccddeeff and `ser_ready` = 1: words 0x00112233, 0x44556677, 0x8899aabb, 0xccddeeff on four consecutive cycles; `ser_last` only on the fourth; level returns to 0.
- `AES_data_out_valid` held high for 50 cycles: exactly one block (4 words) is emitted and level peaks at 1.
- `ser_ready` = 0 with three captures at DEPTH = 2: level reaches 2, the third block is dropped, `ser_ovf` = 1. Releasing ready then emits the first two blocks intact.
- Level = 2 and a new capture on the same cycle as the idx-3 transfer: no drop, level stays 2, `ser_ovf` stays 0.
- Reset asserted after word 1 has transferred: outputs clear immediately. After release, a new block emits from word 0.
- Build with `AES_SER_BSWAP_EN`, first test's block: first word 0x33221100, last word 0xffeeddcc.
